// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment scanner.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/display_scan_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous display update.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan
  import display_pkg::*;
#(
  parameter int PRESCALE = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [1:0]  digit_idx,
  output logic [3:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int         PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  digit_idx_t    r_digit_idx;
  logic [15:0]   r_shadow_digits;
  logic [3:0]    r_shadow_dp;
  logic          r_pending;
  logic [15:0]   r_disp_digits;
  logic [3:0]    r_disp_dp;

  logic          w_tick;
  logic          w_boundary;
  logic [3:0]    w_cur_digit;
  logic [6:0]    w_seg_dec;
  logic [6:0]    w_seg_final;

  assign w_tick     = (r_presc == PMAX);
  assign w_boundary = w_tick && (r_digit_idx == DIG3);
  assign digit_idx  = r_digit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_digit_idx <= DIG0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_digit_idx <= digit_idx_t'(2'(r_digit_idx + 2'd1));
      end
    end
  end

  // Display registers only change on a frame boundary so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      r_pending       <= 1'b0;
      r_disp_digits   <= '0;
      r_disp_dp       <= '0;
    end else if (load && w_boundary) begin
      r_shadow_digits <= digits_in;
      r_shadow_dp     <= dp_in;
      r_disp_digits   <= digits_in;
      r_disp_dp       <= dp_in;
      r_pending       <= 1'b0;
    end else if (load) begin
      r_shadow_digits <= digits_in;
      r_shadow_dp     <= dp_in;
      r_pending       <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_disp_digits <= r_shadow_digits;
      r_disp_dp     <= r_shadow_dp;
      r_pending     <= 1'b0;
    end
  end

  assign w_cur_digit = 4'(r_disp_digits >> {r_digit_idx, 2'b00});

  seg7_decode u_seg7_decode (
    .bcd   (w_cur_digit),
    .seg_n (w_seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] w_blank;

  // A digit blanks only when it and every more significant digit are zero.
  always_comb begin
    w_blank    = 4'b0000;
    w_blank[3] = (r_disp_digits[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_disp_digits[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (r_disp_digits[7:4] == 4'd0);
  end

  assign w_seg_final = w_blank[r_digit_idx] ? SEG_BLANK : w_seg_dec;
`else
  assign w_seg_final = w_seg_dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_n <= 4'b1111;
      seg_n   <= SEG_BLANK;
      dp_n    <= 1'b1;
    end else begin
      anode_n <= ~(4'b0001 << r_digit_idx);
      seg_n   <= w_seg_final;
      dp_n    <= ~r_disp_dp[r_digit_idx];
    end
  end

endmodule
